// File: rtl/mm_bram_pkg.sv
// Shared constants, types and byte-merge helper for the MBRAM responder.
package mm_bram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned LIMB_W = 17;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BE_W-1:0]   be_t;

    // Take byte lane k from new_word where be[k] is set, otherwise from old_word.
    function automatic word_t merge_bytes(word_t old_word, word_t new_word, be_t be);
        word_t res;
        for (int k = 0; k < int'(BE_W); k++) begin
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mm_bram_addr_dec.sv
// Byte address decoder for the master port: word index plus alignment/range checks.
module mm_bram_addr_dec #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             misalign_o,
    output logic             out_of_range_o
);

    assign idx_o          = addr_i[IDX_W+1:2];
    assign misalign_o     = |addr_i[1:0];
    assign out_of_range_o = |addr_i[31:IDX_W+2];

endmodule

// File: rtl/mm_bram_responder.sv
// MBRAM responder: master byte-enable port plus host word port over one memory.
// Define MM_BRAM_OUT_REG_EN to add an output register on both read paths (latency 2).
module mm_bram_responder #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned LIMB_W = mm_bram_pkg::LIMB_W,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             BRAM_en_i,
    input  logic [3:0]       BRAM_we_i,
    input  logic [31:0]      BRAM_addr_i,
    input  logic [31:0]      BRAM_din_i,
    output logic [31:0]      BRAM_dout_o,
    input  logic             host_en_i,
    input  logic             host_we_i,
    input  logic [IDX_W-1:0] host_addr_i,
    input  logic [31:0]      host_wdata_i,
    output logic [31:0]      host_rdata_o,
    output logic             host_rvalid_o,
    output logic             misalign_err_o,
    output logic             range_err_o,
    output logic             limb_err_o,
    output logic             collision_o
);

    import mm_bram_pkg::*;

    localparam word_t LimbMask = word_t'({WORD_W{1'b1}} << LIMB_W);

    word_t            mem [DEPTH];
    logic [IDX_W-1:0] m_idx;
    logic             m_misalign, m_oor;
    logic             m_wr, h_wr, h_rd, collide;
    word_t            lane_mask, m_base;

    word_t m_dout_d, m_dout_q, h_rdata_d, h_rdata_q;
    logic  h_rvalid_d, h_rvalid_q;
    logic  misalign_d, misalign_q, range_d, range_q;
    logic  limb_d, limb_q, collision_d, collision_q;

    mm_bram_addr_dec #(
        .DEPTH (DEPTH)
    ) u_addr_dec (
        .addr_i         (BRAM_addr_i),
        .idx_o          (m_idx),
        .misalign_o     (m_misalign),
        .out_of_range_o (m_oor)
    );

    assign m_wr    = BRAM_en_i && (BRAM_we_i != '0) && !m_oor;
    assign h_wr    = host_en_i && host_we_i;
    assign h_rd    = host_en_i && !host_we_i;
    assign collide = m_wr && h_wr && (m_idx == host_addr_i);
    // On a collision the host word supplies the lanes the master leaves alone.
    assign m_base  = collide ? host_wdata_i : mem[m_idx];

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < int'(BE_W); k++) begin
            lane_mask[8*k +: 8] = {8{BRAM_we_i[k]}};
        end
    end

    // Writes issued in a reset cycle are discarded; contents are never cleared.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (h_wr && !collide) begin
                mem[host_addr_i] <= host_wdata_i;
            end
            if (m_wr) begin
                mem[m_idx] <= merge_bytes(m_base, BRAM_din_i, BRAM_we_i);
            end
        end
    end

    always_comb begin
        m_dout_d    = m_dout_q;
        h_rdata_d   = h_rdata_q;
        h_rvalid_d  = h_rd;
        misalign_d  = misalign_q;
        range_d     = range_q;
        limb_d      = limb_q;
        collision_d = collision_q;
        if (BRAM_en_i) begin
            m_dout_d = m_oor ? '0 : mem[m_idx];
            if (m_misalign) misalign_d = 1'b1;
            if (m_oor) range_d = 1'b1;
            if ((BRAM_we_i != '0) && |(BRAM_din_i & lane_mask & LimbMask)) limb_d = 1'b1;
        end
        if (h_rd) begin
            h_rdata_d = mem[host_addr_i];
        end
        if (collide) begin
            collision_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            m_dout_q    <= '0;
            h_rdata_q   <= '0;
            h_rvalid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            range_q     <= 1'b0;
            limb_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            m_dout_q    <= m_dout_d;
            h_rdata_q   <= h_rdata_d;
            h_rvalid_q  <= h_rvalid_d;
            misalign_q  <= misalign_d;
            range_q     <= range_d;
            limb_q      <= limb_d;
            collision_q <= collision_d;
        end
    end

`ifdef MM_BRAM_OUT_REG_EN
    word_t m_dout_q2, h_rdata_q2;
    logic  h_rvalid_q2;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            m_dout_q2   <= '0;
            h_rdata_q2  <= '0;
            h_rvalid_q2 <= 1'b0;
        end else begin
            m_dout_q2   <= m_dout_q;
            h_rdata_q2  <= h_rdata_q;
            h_rvalid_q2 <= h_rvalid_q;
        end
    end

    assign BRAM_dout_o   = m_dout_q2;
    assign host_rdata_o  = h_rdata_q2;
    assign host_rvalid_o = h_rvalid_q2;
`else
    assign BRAM_dout_o   = m_dout_q;
    assign host_rdata_o  = h_rdata_q;
    assign host_rvalid_o = h_rvalid_q;
`endif

    assign misalign_err_o = misalign_q;
    assign range_err_o    = range_q;
    assign limb_err_o     = limb_q;
    assign collision_o    = collision_q;

endmodule

// File: tb/tb_mm_bram_responder.sv
// Scoreboard bench for mm_bram_responder; follows MM_BRAM_OUT_REG_EN for read latency.
module tb_mm_bram_responder;

`ifdef MM_BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_en;
    logic [3:0]  m_we;
    logic [31:0] m_addr, m_din, m_dout;
    logic        h_en, h_we;
    logic [5:0]  h_idx;
    logic [31:0] h_wd, h_rd;
    logic        h_rv, f_mis, f_rng, f_limb, f_col;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t mq[$];
    exp_t hq[$];
    logic [31:0] words [8];

    mm_bram_responder dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .BRAM_en_i      (m_en),
        .BRAM_we_i      (m_we),
        .BRAM_addr_i    (m_addr),
        .BRAM_din_i     (m_din),
        .BRAM_dout_o    (m_dout),
        .host_en_i      (h_en),
        .host_we_i      (h_we),
        .host_addr_i    (h_idx),
        .host_wdata_i   (h_wd),
        .host_rdata_o   (h_rd),
        .host_rvalid_o  (h_rv),
        .misalign_err_o (f_mis),
        .range_err_o    (f_rng),
        .limb_err_o     (f_limb),
        .collision_o    (f_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: master results are due at a fixed cycle, host results on rvalid.
    always @(negedge clk) begin
        while (mq.size() > 0 && mq[0].due <= cyc) begin
            exp_t e;
            e = mq.pop_front();
            check_eq(e.tag, m_dout, e.val);
        end
        if (h_rv) begin
            if (hq.size() == 0) begin
                check_eq("host_unexpected_rvalid", 32'(h_rv), 32'd0);
            end else begin
                exp_t e;
                e = hq.pop_front();
                check_eq(e.tag, h_rd, e.val);
                check_eq({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end
        if (hq.size() > 0 && cyc > hq[0].due) begin
            exp_t e;
            e = hq.pop_front();
            check_eq({e.tag, "_missing_rvalid"}, 32'(h_rv), 32'd1);
        end
    end

    task automatic step(input logic me, input logic [3:0] mw, input logic [31:0] ma,
                        input logic [31:0] md, input logic he, input logic hw,
                        input logic [5:0] hi, input logic [31:0] hd, input logic r);
        m_en = me; m_we = mw; m_addr = ma; m_din = md;
        h_en = he; h_we = hw; h_idx = hi; h_wd = hd; rst = r;
        @(posedge clk);
        #1;
        m_en = 1'b0; m_we = '0; h_en = 1'b0; h_we = 1'b0; rst = 1'b0;
    endtask

    task automatic push_m(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.val = v; e.due = cyc + LAT;
        mq.push_back(e);
    endtask

    task automatic push_h(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.val = v; e.due = cyc + LAT;
        hq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0, 0);
    endtask

    task automatic h_write(input logic [5:0] idx, input logic [31:0] d);
        step(0, 4'h0, 32'h0, 32'h0, 1, 1, idx, d, 0);
    endtask

    task automatic h_read(input string tag, input logic [5:0] idx, input logic [31:0] exp);
        push_h(tag, exp);
        step(0, 4'h0, 32'h0, 32'h0, 1, 0, idx, 32'h0, 0);
    endtask

    task automatic m_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        push_m(tag, exp);
        step(1, 4'h0, a, 32'h0, 0, 0, 6'd0, 32'h0, 0);
    endtask

    task automatic m_write(input string tag, input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] d, input logic [31:0] exp_old);
        push_m(tag, exp_old);
        step(1, we, a, d, 0, 0, 6'd0, 32'h0, 0);
    endtask

    initial begin
        m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
        h_en = 0; h_we = 0; h_idx = 0; h_wd = 0; rst = 1;
        step(0, 4'h0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0, 1);
        step(0, 4'h0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0, 1);
        check_eq("rst_dout", m_dout, 32'h0);
        check_eq("rst_rdata", h_rd, 32'h0);
        check_eq("rst_rvalid", 32'(h_rv), 32'd0);
        check_eq("rst_flags", {28'd0, f_mis, f_rng, f_limb, f_col}, 32'h0);

        // Host preload, master readback, then dout holds while idle.
        h_write(6'd5, 32'h0001_ABCD);
        m_read("s1_read", 32'h14, 32'h0001_ABCD);
        idle(LAT + 2);
        check_eq("s1_hold", m_dout, 32'h0001_ABCD);
        check_eq("s1_flags", {28'd0, f_mis, f_rng, f_limb, f_col}, 32'h0);

        // Limb boundary: high bits only in disabled lanes, and bit LIMB_W-1 set.
        h_write(6'd4, 32'h0);
        m_write("s4_part_old", 32'h10, 4'b0011, 32'hFFFC_ABCD, 32'h0);
        m_read("s4_part_rd", 32'h10, 32'h0000_ABCD);
        m_write("s4_bit16_old", 32'h10, 4'hF, 32'h0001_FFFF, 32'h0000_ABCD);
        m_read("s4_bit16_rd", 32'h10, 32'h0001_FFFF);
        idle(LAT);
        check_eq("s4_limb_clear", 32'(f_limb), 32'd0);

        // Partial byte write and read-first behaviour on both ports.
        h_write(6'd2, 32'hFFFF_FFFF);
        m_write("s2_wr_old", 32'h08, 4'b0011, 32'h0000_1234, 32'hFFFF_FFFF);
        h_read("s2_host_rd", 6'd2, 32'hFFFF_1234);
        m_write("s2_rf_master", 32'h08, 4'hF, 32'h0000_5555, 32'hFFFF_1234);
        push_m("s2_mw_hr_master", 32'h0000_5555);
        push_h("s2_mw_hr_host", 32'h0000_5555);
        step(1, 4'hF, 32'h08, 32'h0000_7777, 1, 0, 6'd2, 32'h0, 0);
        h_read("s2_after", 6'd2, 32'h0000_7777);
        idle(LAT + 1);
        check_eq("s2_no_collision", 32'(f_col), 32'd0);

        // Out-of-range write aliases index 0 but must be dropped.
        h_write(6'd0, 32'h0000_0042);
        m_read("s3_pre", 32'h0, 32'h0000_0042);
        m_write("s3_oor_wr", 32'h400, 4'hF, 32'h0000_1111, 32'h0);
        m_read("s3_oor_rd", 32'h400, 32'h0);
        h_read("s3_idx0", 6'd0, 32'h0000_0042);
        idle(LAT + 1);
        check_eq("s3_range", 32'(f_rng), 32'd1);
        check_eq("s3_misalign_clear", 32'(f_mis), 32'd0);

        // Limb violation still writes; misaligned read ignores low bits.
        h_write(6'd3, 32'h0000_0001);
        m_write("s4_limb_old", 32'h0C, 4'hF, 32'h0002_0000, 32'h0000_0001);
        check_eq("s4_limb", 32'(f_limb), 32'd1);
        m_read("s4_misalign_rd", 32'h0D, 32'h0002_0000);
        idle(LAT);
        check_eq("s4_misalign", 32'(f_mis), 32'd1);

        // Same-word write collision.
        h_write(6'd7, 32'h0);
        push_m("s5_col_old", 32'h0);
        step(1, 4'b0001, 32'h1C, 32'h0000_00AA, 1, 1, 6'd7, 32'h1122_3344, 0);
        h_read("s5_merged", 6'd7, 32'h1122_33AA);
        idle(LAT + 1);
        check_eq("s5_collision", 32'(f_col), 32'd1);
        check_eq("s5_range_sticky", 32'(f_rng), 32'd1);

        // Scoreboard sweep over host-written words.
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom & 32'h0001_FFFF;
            h_write(6'(16 + i), words[i]);
        end
        for (int i = 0; i < 8; i++) begin
            m_read("sweep_master", 32'(64 + 4 * i), words[i]);
            h_read("sweep_host", 6'(16 + i), words[i]);
        end
        idle(LAT + 1);

        // Reset in the same cycle as a write and a host read.
        h_write(6'd9, 32'h0BAD_F00D);
        idle(LAT + 1);
        step(1, 4'hF, 32'h24, 32'h0000_0001, 1, 0, 6'd9, 32'h0, 1);
        check_eq("s6_dout", m_dout, 32'h0);
        check_eq("s6_rdata", h_rd, 32'h0);
        check_eq("s6_flags", {28'd0, f_mis, f_rng, f_limb, f_col}, 32'h0);
        idle(LAT + 1);
        check_eq("s6_rvalid", 32'(h_rv), 32'd0);
        m_read("s6_word_kept", 32'h24, 32'h0BAD_F00D);
        h_read("s6_host_kept", 6'd9, 32'h0BAD_F00D);
        idle(LAT + 3);
        check_eq("master_q_drained", 32'(mq.size()), 32'd0);
        check_eq("host_q_drained", 32'(hq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
